pong_sync_decoder: RTL and testbench
====================================

# pong_sync_decoder

Video-receiving end of the pong raster: consumes the active-high `hsync`/`vsync`, blanking and 4-bit intensity produced by the game core and recovers pixel coordinates, line/frame geometry and a lock flag. It sits between the pong core and downstream consumers such as a scan converter, OSD mixer or frame capture, which need `x`/`y` instead of raw sync. All inputs share the core's pixel clock.

## Interface
- `LOCK_FRAMES`, 2, consecutive identical frames required before `locked` asserts (1..15).
- `clk7_159`  in  1  pixel clock, 7.159 MHz.
- `_rst`  in  1  reset, asynchronous assert, active-low.
- `hsync`, `vsync`  in  1 each  active-high sync from the core.
- `hblank`, `vblank`  in  1 each  active-high blanking.
- `video`  in  4  pixel intensity.
- `x`  out  9  clocks since the last line start; saturates at 511.
- `y`  out  9  lines since the last frame start; saturates at 511.
- `new_line`, `new_frame`  out  1 each  one-cycle pulses, high while `x`==0 (and `y`==0 for `new_frame`).
- `line_len`  out  10  length of the last complete line, in clocks.
- `frame_lines`  out  10  line count of the last complete frame.
- `locked`  out  1  geometry stable.
- `pix_valid`  out  1  `locked` & not blanked, aligned with `x`/`y`.
- `pix`  out  4  delayed `video` when `pix_valid`, else 0.

## Operation
- Front end: `hsync`, `vsync`, `hblank`, `vblank` and `video` pass through a 2-register delay (S1, S2). An edge is S1=1 and S2=0.
- An hsync edge sets `x`<=0 and `line_len`<=`x`+1, increments `y` (saturating at 511), and pulses `new_line`. Otherwise `x` increments, saturating at 511.
- A vsync edge sets `y`<=0 and `frame_lines`<=`y`+1, and pulses `new_frame`. On a simultaneous hsync edge, vsync wins for `y` and the hsync rules still apply to `x` and `line_len`.
- Lock FSM, with state reg `ref_len[9:0]`, `ref_lines[9:0]` and `cnt[3:0]`:
  - SEARCH (reset state): each hsync edge stores `ref_len`. On a vsync edge, if `ref_len`≠0, it stores `ref_lines`, clears `cnt` and goes to MEASURE.
  - MEASURE: on an hsync edge, a new length ≠ `ref_len` sends it to SEARCH. On a vsync edge:
    - new `frame_lines` ≠ `ref_lines`: `ref_lines` updates and `cnt`<=0.
    - Otherwise `cnt`++. On reaching `LOCK_FRAMES` it goes to LOCKED.
  - LOCKED: a line-length mismatch, a frame-line mismatch or `x` reaching 511 sends it to SEARCH.
  - An `x`=511 timeout in MEASURE also goes to SEARCH.
- `locked` = (state==LOCKED), registered.
- `pix_valid` = `locked` & ~S2.hblank & ~S2.vblank. `pix` = S2.video & {4{`pix_valid`}}.

## Timing
- Input high before rising edge k: S1 at k, S2 at k+1. Edge outputs (`x`=0, pulses, `line_len`, `frame_lines`) are visible after edge k+1, giving 2-cycle sync-to-coordinate latency.
- `pix`/`pix_valid` use the same 2-cycle delay, so they align with `x`.
- `locked` falls in the cycle after the edge that detected a mismatch or timeout.
- Reset values: all outputs 0 and FSM in SEARCH. Reset mid-line restarts cleanly, with no output until lock.
- Widths: `x`/`y` are 9-bit saturating. `line_len`/`frame_lines` are `x`+1/`y`+1 zero-extended to 10 bits, so the maximum is 512.
- Pong nominal values: `line_len`=455, `frame_lines`=262.

## Configuration
- `SYNC_DEGLITCH_EN` defined: a third register S3 is added. An edge requires S1=S2=1 and S3=0, so 1-clock sync glitches are ignored. Latency becomes 3 cycles, and blank/video are delayed by one extra stage to stay aligned.
- Undefined: 2-stage path as specified. A 1-clock pulse counts as an edge.

## Test plan
- Reset mid-frame, then nominal pong timing (455×262) -> `frame_lines`=262 after the 2nd vsync edge, and `locked`=1 no later than the cycle after the 4th vsync edge (`LOCK_FRAMES`=2).
- Locked stream, one line shortened to 454 -> `locked`=0 the cycle after that hsync edge. It re-locks after 4 further vsync edges.
- `hsync` held low for 600 clocks -> `x` sticks at 511, `locked` drops the cycle after `x` reaches 511, and `y` is unchanged.
- `hsync` and `vsync` rising in the same cycle -> `x`=0 and `y`=0, and `new_line` and `new_frame` both pulse.
- Locked, with `video`=4'hf in the active area -> `pix`=4'hf exactly 2 clocks later with `pix_valid`=1. During `hblank`, `pix`=0.
- With `SYNC_DEGLITCH_EN`: inject a 1-clock `hsync` glitch -> `x` is unaffected and `locked` stays 1. Without the macro the same glitch drops `locked`.

Source files
------------

// File: rtl/pong_sync_decoder.sv
// -----------------------------------------------------------------------------
// pong_sync_decoder
//
// Receiving end of the pong raster. Takes the core's active-high sync,
// blanking and 4-bit intensity (all on the core's pixel clock), and recovers
// pixel coordinates, line/frame geometry and a lock flag for downstream
// consumers (scan converter, OSD mixer, frame capture).
//
// Parameters
//   LOCK_FRAMES   consecutive identical frames before `locked` rises (1..15)
//
// Ports
//   clk7_159      in   1   pixel clock (7.159 MHz)
//   _rst          in   1   asynchronous active-low reset
//   hsync, vsync  in   1   active-high sync
//   hblank,vblank in   1   active-high blanking
//   video         in   4   pixel intensity
//   x             out  9   clocks since the last line start, saturates at 511
//   y             out  9   lines since the last frame start, saturates at 511
//   new_line      out  1   one-cycle pulse while x == 0
//   new_frame     out  1   one-cycle pulse while y == 0
//   line_len      out 10   length of the last complete line (x+1)
//   frame_lines   out 10   line count of the last complete frame (y+1)
//   locked        out  1   geometry stable
//   pix_valid     out  1   locked and not blanked, aligned with x/y
//   pix           out  4   delayed video while pix_valid, else 0
//
// Build option
//   SYNC_DEGLITCH_EN  when defined, a third front-end stage is added and a
//                     sync edge needs two consecutive high samples, so a
//                     one-clock sync glitch is ignored. Sync-to-coordinate
//                     latency grows from 2 to 3 clocks; blank/video get the
//                     same extra stage so pix stays aligned with x.
// -----------------------------------------------------------------------------
module pong_sync_decoder #(
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk7_159,
    input  logic       _rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hblank,
    input  logic       vblank,
    input  logic [3:0] video,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       new_line,
    output logic       new_frame,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       locked,
    output logic       pix_valid,
    output logic [3:0] pix
);

    // One sample of everything the core hands us.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic [3:0] video;
    } raster_t;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    localparam logic [8:0] COORD_MAX   = 9'd511;
    localparam logic [4:0] LOCK_TARGET = 5'(LOCK_FRAMES);

    // -------------------------------------------------------------------------
    // Front end: delay line and edge detection
    // -------------------------------------------------------------------------
    raster_t raw;
    raster_t s1_q;
    raster_t s2_q;

    logic       hs_edge;
    logic       vs_edge;
    logic       pix_hb;
    logic       pix_vb;
    logic [3:0] pix_video;

    assign raw = {hsync, vsync, hblank, vblank, video};

`ifdef SYNC_DEGLITCH_EN
    raster_t s3_q;

    always_ff @(posedge clk7_159 or negedge _rst) begin
        if (!_rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make this a true shift register;
            // with blocking ones every stage would collapse onto `raw`.
            s1_q <= raw;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Sync must be seen high on two consecutive samples to count as an edge.
    assign hs_edge   = s1_q.hs & s2_q.hs & ~s3_q.hs;
    assign vs_edge   = s1_q.vs & s2_q.vs & ~s3_q.vs;
    assign pix_hb    = s3_q.hb;
    assign pix_vb    = s3_q.vb;
    assign pix_video = s3_q.video;
`else
    always_ff @(posedge clk7_159 or negedge _rst) begin
        if (!_rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make this a true shift register;
            // with blocking ones every stage would collapse onto `raw`.
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    assign hs_edge   = s1_q.hs & ~s2_q.hs;
    assign vs_edge   = s1_q.vs & ~s2_q.vs;
    assign pix_hb    = s2_q.hb;
    assign pix_vb    = s2_q.vb;
    assign pix_video = s2_q.video;
`endif

    // -------------------------------------------------------------------------
    // Coordinate counters and measured geometry
    // -------------------------------------------------------------------------
    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [9:0] line_len_q, line_len_d;
    logic [9:0] frame_lines_q, frame_lines_d;
    logic       new_line_q;
    logic       new_frame_q;

    // x+1 / y+1 carried at 10 bits so a saturated count reports 512.
    logic [9:0] x_inc;
    logic [9:0] y_inc;
    logic       x_sat;
    logic       y_sat;

    assign x_inc = {1'b0, x_q} + 10'd1;
    assign y_inc = {1'b0, y_q} + 10'd1;
    assign x_sat = (x_q == COORD_MAX);
    assign y_sat = (y_q == COORD_MAX);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        x_d           = x_sat ? x_q : x_inc[8:0];
        y_d           = y_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;

        if (hs_edge) begin
            x_d        = '0;
            line_len_d = x_inc;
            y_d        = y_sat ? y_q : y_inc[8:0];
        end

        // Placed after the hsync branch so a coincident vsync wins for y.
        if (vs_edge) begin
            y_d           = '0;
            frame_lines_d = y_inc;
        end
    end

    always_ff @(posedge clk7_159 or negedge _rst) begin
        if (!_rst) begin
            x_q           <= '0;
            y_q           <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            new_line_q    <= 1'b0;
            new_frame_q   <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            new_line_q    <= hs_edge;
            new_frame_q   <= vs_edge;
        end
    end

    // -------------------------------------------------------------------------
    // Lock FSM
    //
    // SEARCH tracks the most recent line length. The first vsync seen with a
    // known line length captures a reference frame size and moves to MEASURE,
    // which counts consecutive frames that repeat that size. A wrong line
    // length or a runaway line (x stuck at 511) drops straight back to SEARCH.
    // LOCKED holds until any line or frame disagrees with the references.
    // -------------------------------------------------------------------------
    lock_state_e state_q;
    logic [9:0]  ref_len_q;
    logic [9:0]  ref_lines_q;
    logic [3:0]  cnt_q;
    logic        locked_q;

    logic len_mismatch;
    logic lines_mismatch;

    assign len_mismatch   = hs_edge & (x_inc != ref_len_q);
    assign lines_mismatch = vs_edge & (y_inc != ref_lines_q);

    always_ff @(posedge clk7_159 or negedge _rst) begin
        if (!_rst) begin
            state_q     <= ST_SEARCH;
            ref_len_q   <= '0;
            ref_lines_q <= '0;
            cnt_q       <= '0;
            locked_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (hs_edge) begin
                        ref_len_q <= x_inc;
                    end
                    // ref_len_q == 0 means no line has been measured since
                    // reset, so there is nothing to compare frames against.
                    if (vs_edge && (ref_len_q != '0)) begin
                        ref_lines_q <= y_inc;
                        cnt_q       <= '0;
                        state_q     <= ST_MEASURE;
                    end
                end

                ST_MEASURE: begin
                    if (x_sat || len_mismatch) begin
                        state_q <= ST_SEARCH;
                    end else if (vs_edge) begin
                        if (lines_mismatch) begin
                            ref_lines_q <= y_inc;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            if (({1'b0, cnt_q} + 5'd1) == LOCK_TARGET) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_LOCKED: begin
                    if (x_sat || len_mismatch || lines_mismatch) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign x           = x_q;
    assign y           = y_q;
    assign new_line    = new_line_q;
    assign new_frame   = new_frame_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;

    // Blank/video come from the same delay stage that feeds edge detection,
    // so pix lines up with the x/y the counters report in the same cycle.
    assign pix_valid = locked_q & ~pix_hb & ~pix_vb;
    assign pix       = pix_video & {4{pix_valid}};

endmodule

// File: tb/tb_pong_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_pong_sync_decoder
//
// Drives a pong-style raster (455-clock lines, shortened frames to keep the
// run short) into pong_sync_decoder. A behavioural model of the decoder runs
// alongside and every output is compared against it on each falling clock
// edge; directed literal checks pin the model at the interesting points.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pong_sync_decoder;

    localparam int LOCK_FRAMES = 2;
`ifdef SYNC_DEGLITCH_EN
    localparam int LAT      = 3;
    localparam bit DEGLITCH = 1'b1;
`else
    localparam int LAT      = 2;
    localparam bit DEGLITCH = 1'b0;
`endif
    localparam int H_TOTAL  = 455;
    localparam int V_TOTAL  = 8;
    localparam int SHORT_Y  = 3;
    localparam int HALF_PER = 70;

    logic       clk7_159 = 1'b0;
    logic       _rst     = 1'b0;
    logic       hsync    = 1'b0;
    logic       vsync    = 1'b0;
    logic       hblank   = 1'b0;
    logic       vblank   = 1'b0;
    logic [3:0] video    = 4'h0;
    logic [8:0] x;
    logic [8:0] y;
    logic       new_line;
    logic       new_frame;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       locked;
    logic       pix_valid;
    logic [3:0] pix;

    pong_sync_decoder #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) dut (
        .clk7_159    (clk7_159),
        ._rst        (_rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .video       (video),
        .x           (x),
        .y           (y),
        .new_line    (new_line),
        .new_frame   (new_frame),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked),
        .pix_valid   (pix_valid),
        .pix         (pix)
    );

    always #HALF_PER clk7_159 = ~clk7_159;

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: input history, coordinates, and lock tracking
    // -------------------------------------------------------------------------
    localparam int HUNT = 0, CONFIRM = 1, HOLD = 2;

    logic [3:0] hs_h, vs_h, hb_h, vb_h;   // bit 0 = most recent sample
    logic [3:0] vid_h [4];
    int m_x, m_y, m_len, m_lines, m_phase, want_len, want_lines, agree;
    bit m_nl, m_nf, m_lk, m_pv;
    int m_pix;

    function automatic int sat511(input int v);
        return (v > 511) ? 511 : v;
    endfunction

    task automatic model_reset();
        hs_h = '0; vs_h = '0; hb_h = '0; vb_h = '0;
        for (int i = 0; i < 4; i++) vid_h[i] = '0;
        m_x = 0; m_y = 0; m_len = 0; m_lines = 0;
        m_phase = HUNT; want_len = 0; want_lines = 0; agree = 0;
        m_nl = 0; m_nf = 0; m_lk = 0; m_pv = 0; m_pix = 0;
    endtask

    task automatic model_tick();
        bit hs_ev, vs_ev, runaway, bad_line;
        int len, lines, src;
        if (DEGLITCH) begin
            hs_ev = hs_h[0] & hs_h[1] & ~hs_h[2];
            vs_ev = vs_h[0] & vs_h[1] & ~vs_h[2];
        end else begin
            hs_ev = hs_h[0] & ~hs_h[1];
            vs_ev = vs_h[0] & ~vs_h[1];
        end
        len      = m_x + 1;
        lines    = m_y + 1;
        runaway  = (m_x == 511);
        bad_line = hs_ev && (len != want_len);

        if (m_phase == HUNT) begin
            if (vs_ev && want_len != 0) begin
                want_lines = lines;
                agree      = 0;
                m_phase    = CONFIRM;
            end
            if (hs_ev) want_len = len;
        end else if (m_phase == CONFIRM) begin
            if (runaway || bad_line) m_phase = HUNT;
            else if (vs_ev) begin
                if (lines != want_lines) begin
                    want_lines = lines;
                    agree      = 0;
                end else begin
                    agree++;
                    if (agree >= LOCK_FRAMES) m_phase = HOLD;
                end
            end
        end else begin
            if (runaway || bad_line || (vs_ev && lines != want_lines)) m_phase = HUNT;
        end
        m_lk = (m_phase == HOLD);

        if (hs_ev) m_len = len;
        if (vs_ev) m_lines = lines;
        m_x  = hs_ev ? 0 : sat511(m_x + 1);
        m_y  = vs_ev ? 0 : (hs_ev ? sat511(m_y + 1) : m_y);
        m_nl = hs_ev;
        m_nf = vs_ev;

        hs_h = {hs_h[2:0], hsync};
        vs_h = {vs_h[2:0], vsync};
        hb_h = {hb_h[2:0], hblank};
        vb_h = {vb_h[2:0], vblank};
        for (int i = 3; i > 0; i--) vid_h[i] = vid_h[i-1];
        vid_h[0] = video;

        src   = DEGLITCH ? 2 : 1;
        m_pv  = m_lk && !hb_h[src] && !vb_h[src];
        m_pix = m_pv ? int'(vid_h[src]) : 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk7_159 or negedge _rst);
            if (!_rst) model_reset();
            else       model_tick();
        end
    end

    // Compare every output against the model away from the active edge.
    initial begin
        logic [63:0] act, exp;
        forever begin
            @(negedge clk7_159);
            act = {18'd0, x, y, line_len, frame_lines, new_line, new_frame, locked, pix_valid, pix};
            exp = {18'd0, 9'(m_x), 9'(m_y), 10'(m_len), 10'(m_lines),
                   m_nl, m_nf, m_lk, m_pv, 4'(m_pix)};
            check("model_outputs", act, exp);
        end
    end

    // -------------------------------------------------------------------------
    // Raster generator (one step = one falling edge)
    // -------------------------------------------------------------------------
    int gx = 100, gy = 3;  // next coordinate to drive; starts mid-frame
    int sup = 0;           // clocks left with hsync forced low
    bit short_arm  = 0;
    bit glitch_arm = 0;

    task automatic step();
        int len;
        @(negedge clk7_159);
        len    = (short_arm && gy == SHORT_Y) ? H_TOTAL - 1 : H_TOTAL;
        hsync  = (gx < 32) && (sup == 0);
        if (glitch_arm && gx == 300) begin
            hsync      = 1'b1;
            glitch_arm = 0;
        end
        vsync  = (gy < 2);
        hblank = (gx < 64) || (gx >= 440);
        vblank = (gy < 2);
        video  = (gx == 200) ? 4'hf : 4'((gx * 3 + gy) % 15);
        if (sup > 0) sup--;
        gx++;
        if (gx == len) begin
            gx = 0;
            if (short_arm && gy == SHORT_Y) short_arm = 0;
            gy = (gy + 1) % V_TOTAL;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int tx, input int ty);
        int guard = 0;
        while (!(gx == tx && gy == ty) && guard < 20000) begin
            step();
            guard++;
        end
        if (guard >= 20000) check("run_to_bound", 64'(guard), 64'(0));
    endtask

    // Drive the next frame start and return LAT clocks later, when the
    // resulting edge must be visible on the outputs.
    task automatic next_frame_edge();
        run_to(0, 0);
        step();
        steps(LAT);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        // Reset while the raster runs mid-frame, mid-line.
        steps(5);
        check("rst_x",           x,           0);
        check("rst_y",           y,           0);
        check("rst_line_len",    line_len,    0);
        check("rst_frame_lines", frame_lines, 0);
        check("rst_locked",      locked,      0);
        check("rst_pix_valid",   pix_valid,   0);
        check("rst_pix",         pix,         0);
        check("rst_pulses",      {new_line, new_frame}, 0);
        _rst = 1'b1;

        // First frame start: coincident hsync/vsync edge.
        next_frame_edge();
        check("sim_edge_x",      x,     0);
        check("sim_edge_y",      y,     0);
        check("sim_edge_pulses", {new_line, new_frame}, 2'b11);
        check("sim_edge_locked", locked, 0);

        // Second frame start: a full frame has been measured.
        next_frame_edge();
        check("frame_lines_2nd", frame_lines, V_TOTAL);
        check("line_len_nom",    line_len,    H_TOTAL);

        // Third frame start; fourth one brings lock.
        next_frame_edge();
        run_to(0, 0);
        step();
        steps(LAT - 1);
        check("lock_before_4th", locked, 0);
        step();
        check("lock_after_4th",  locked, 1);

        // Full-intensity pixel in the active area, then a blanked pixel.
        run_to(200, 5);
        step();
        steps(LAT);
        check("pix_active_x",     x,         200);
        check("pix_active_y",     y,         5);
        check("pix_active_value", pix,       4'hf);
        check("pix_active_valid", pix_valid, 1);
        run_to(10, 6);
        step();
        steps(LAT);
        check("pix_hblank_value", pix,       0);
        check("pix_hblank_valid", pix_valid, 0);

        // Shortened line 3 in the next frame.
        short_arm = 1;
        run_to(0, 4);
        step();
        steps(LAT - 1);
        check("short_still_locked", locked, 1);
        step();
        check("short_line_len", line_len, H_TOTAL - 1);
        check("short_unlocked", locked,   0);
        for (int i = 0; i < 4; i++) next_frame_edge();
        check("short_relocked", locked, 1);

        // hsync held low for 600 clocks starting just after line 4's pulse.
        run_to(0, 4);
        step();
        steps(39);
        sup = 600;
        steps(LAT + 511 - 39);
        check("tmo_x_reach",      x,      511);
        check("tmo_locked_reach", locked, 1);
        check("tmo_y_reach",      y,      4);
        step();
        check("tmo_x_stuck",      x,      511);
        check("tmo_unlocked",     locked, 0);
        check("tmo_y_stuck",      y,      4);
        for (int i = 0; i < 4; i++) next_frame_edge();
        check("tmo_relocked", locked, 1);

        // One-clock hsync glitch mid-line.
        run_to(300, 3);
        glitch_arm = 1;
        step();
        steps(LAT);
        check("glitch_x",      x,      DEGLITCH ? 300 : 0);
        check("glitch_locked", locked, DEGLITCH ? 1 : 0);

        steps(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #(64'(2 * HALF_PER) * 64'd90000);
        $display("FAIL watchdog: run exceeded 90000 clocks");
        $fatal(1);
    end

endmodule
